// File: rtl/cic_decim_iq.sv
// Multi-stage CIC decimator for packed {I,Q} baseband samples; two identical channels.
// Define CIC_DECIM_ROUND_EN for round-half-up output with positive saturation.
module cic_decim_iq #(
    parameter int IN_W   = 24,
    parameter int OUT_W  = 24,
    parameter int STAGES = 3,
    parameter int DEC    = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [2*IN_W-1:0]    data_i,
    output logic [2*OUT_W-1:0]   data_o,
    output logic                 valid_o
);
    localparam int PH_W  = $clog2(DEC);
    localparam int ACC_W = IN_W + STAGES * PH_W;
    localparam int DROP  = ACC_W - OUT_W;

    logic [PH_W-1:0]    phase;
    logic               strobe;
    logic [2*OUT_W-1:0] y_all;

    assign strobe = (phase == PH_W'(DEC - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase <= '0;
        end else begin
            phase <= phase + PH_W'(1);
        end
    end

    // Channel 0 is Q (low half), channel 1 is I (high half).
    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic [ACC_W-1:0] x_ext;
        logic [ACC_W-1:0] integ   [STAGES];
        logic [ACC_W-1:0] dly     [STAGES];
        logic [ACC_W-1:0] comb_in [STAGES];
        logic [ACC_W-1:0] comb_out;
        logic [OUT_W-1:0] y;

        assign x_ext = {{(ACC_W-IN_W){data_i[ch*IN_W + IN_W - 1]}}, data_i[ch*IN_W +: IN_W]};

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int k = 0; k < STAGES; k++) begin
                    integ[k] <= '0;
                end
            end else begin
                integ[0] <= integ[0] + x_ext;
                for (int k = 1; k < STAGES; k++) begin
                    integ[k] <= integ[k] + integ[k-1];
                end
            end
        end

        always_comb begin
            comb_out = integ[STAGES-1];
            for (int k = 0; k < STAGES; k++) begin
                comb_in[k] = comb_out;
                comb_out   = comb_out - dly[k];
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int k = 0; k < STAGES; k++) begin
                    dly[k] <= '0;
                end
            end else if (strobe) begin
                for (int k = 0; k < STAGES; k++) begin
                    dly[k] <= comb_in[k];
                end
            end
        end

`ifdef CIC_DECIM_ROUND_EN
        // Widen by one bit so a positive carry out of the rounding add can be caught.
        localparam logic [ACC_W:0] HALF = (ACC_W+1)'(1) << (DROP - 1);
        logic [ACC_W:0] rsum;
        logic           unused_round;

        always_comb begin
            rsum = {comb_out[ACC_W-1], comb_out} + HALF;
            if (rsum[ACC_W] != rsum[ACC_W-1]) begin
                y = {1'b0, {(OUT_W-1){1'b1}}};
            end else begin
                y = rsum[ACC_W-1 -: OUT_W];
            end
        end

        assign unused_round = ^{rsum[ACC_W], rsum[DROP-1:0]};
`else
        logic unused_trunc;

        assign y            = comb_out[ACC_W-1 -: OUT_W];
        assign unused_trunc = ^comb_out[DROP-1:0];
`endif

        assign y_all[ch*OUT_W +: OUT_W] = y;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_o  <= '0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= strobe;
            if (strobe) begin
                data_o <= y_all;
            end
        end
    end

endmodule
